// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite tile memories: palette, tile
// geometry and the writer FSM state encoding. The palette here is the same
// table the read-side tile RAMs decode with, so both ends agree.
package sprite_pkg;

    localparam int TILE_W      = 20;
    localparam int TILE_H      = 20;
    localparam int TILE_PIXELS = TILE_W * TILE_H;
    localparam int ADDR_W      = 9;
    localparam int IDX_W       = 4;
    localparam int PAL_N       = 9;

    localparam logic [11:0] PALETTE [0:PAL_N-1] = '{
        12'h808, 12'h887, 12'h000, 12'hFEF, 12'hFC9,
        12'hE50, 12'hA30, 12'h765, 12'hE30
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sprite_palette_encoder.sv
// Combinational RGB-to-palette-index encoder. Lowest matching index wins;
// an unmatched colour yields index 0 (transparent) with hit low.
module sprite_palette_encoder #(
    parameter int IDX_W = sprite_pkg::IDX_W
) (
    input  logic [11:0]      rgb,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);
    import sprite_pkg::*;

    // Scan from the top entry down so lower indices overwrite higher ones.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = PAL_N - 1; i >= 0; i--) begin
            idx = (rgb == PALETTE[i]) ? IDX_W'(i) : idx;
            hit = hit | (rgb == PALETTE[i]);
        end
    end

endmodule

// File: rtl/sprite_tile_writer.sv
// Streams RGB pixels into a tile memory write port in raster order,
// converting each pixel to its palette index and tracking unmatched pixels.
module sprite_tile_writer #(
    parameter int TILE_PIXELS = sprite_pkg::TILE_PIXELS,
    parameter int ADDR_W      = sprite_pkg::ADDR_W,
    parameter int IDX_W       = sprite_pkg::IDX_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [11:0]       pix_rgb,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [IDX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] miss_count
);
    import sprite_pkg::*;

    state_e            state_r;
    state_e            next_state_s;
    logic              accept_s;
    logic              load_start_s;
    logic              last_s;
    logic [IDX_W-1:0]  enc_idx_s;
    logic              enc_hit_s;

    logic [ADDR_W-1:0] cnt_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [IDX_W-1:0]  wr_data_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [ADDR_W-1:0] miss_r;

    sprite_palette_encoder #(
        .IDX_W (IDX_W)
    ) u_encoder (
        .rgb (pix_rgb),
        .idx (enc_idx_s),
        .hit (enc_hit_s)
    );

    assign last_s       = (cnt_r == ADDR_W'(TILE_PIXELS - 1));
    assign load_start_s = (state_r == ST_IDLE) && start;
    // Ready comes from registered state only so it never loops back to valid.
    assign pix_ready    = (state_r == ST_LOAD);

    // FSM state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and pixel-acceptance decode; abort beats the final pixel.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                accept_s = pix_valid;
                if (abort) begin
                    next_state_s = ST_IDLE;
                end else if (pix_valid && last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Write port, status flags and pixel counter, all registered.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_r     <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            miss_r    <= '0;
        end else begin
            wr_en_r <= accept_s;
            done_r  <= accept_s && last_s && !abort;
            busy_r  <= (next_state_s != ST_IDLE);
            if (load_start_s) begin
                cnt_r  <= '0;
                err_r  <= 1'b0;
                miss_r <= '0;
            end else if (accept_s) begin
                wr_addr_r <= cnt_r;
                wr_data_r <= enc_hit_s ? enc_idx_s : '0;
                if (!last_s) begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
                if (!enc_hit_s) begin
                    err_r <= 1'b1;
                    if (miss_r != ADDR_W'(TILE_PIXELS)) begin
                        miss_r <= miss_r + ADDR_W'(1);
                    end else begin
                        miss_r <= miss_r;
                    end
                end else begin
                    err_r <= err_r;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign miss_count = miss_r;

endmodule

// File: tb/tb_sprite_tile_writer.sv
// Directed bench for sprite_tile_writer with a write scoreboard.
module tb_sprite_tile_writer;

    localparam int TP = 400;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pix_valid = 1'b0;
    logic [11:0] pix_rgb = 12'h000;
    logic        pix_ready;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  miss_count;

    typedef struct packed {
        logic [8:0] addr;
        logic [3:0] data;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   addr_ctr = 0;
    int   done_before = 0;

    logic [11:0] pal [0:8] = '{12'h808, 12'h887, 12'h000, 12'hFEF, 12'hFC9,
                               12'hE50, 12'hA30, 12'h765, 12'hE30};

    sprite_tile_writer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .abort      (abort),
        .pix_valid  (pix_valid),
        .pix_rgb    (pix_rgb),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .miss_count (miss_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] enc(input logic [11:0] rgb);
        logic [3:0] r;
        logic       f;
        r = 4'd0;
        f = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!f && rgb == pal[i]) begin
                r = 4'(i);
                f = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        addr_ctr = 0;
    endtask

    // Drive one cycle of pixel input; an accepted pixel queues its expected write.
    task automatic send(input logic [11:0] rgb, input logic valid, input logic ab);
        exp_t e;
        pix_rgb   = rgb;
        pix_valid = valid;
        abort     = ab;
        if (valid) begin
            e.addr = 9'(addr_ctr);
            e.data = enc(rgb);
            e.last = (addr_ctr == TP - 1) && !ab;
            q.push_back(e);
            addr_ctr++;
        end
        tick();
        pix_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(pix_ready), 32'd0);
        check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check({tag, "_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_data"}, 32'(wr_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_miss"}, 32'(miss_count), 32'd0);
    endtask

    // Scoreboard: each write seen mid-cycle must match the oldest queued pixel.
    always @(negedge Clk) begin
        if (done) begin
            done_seen++;
        end
        if (wr_en) begin
            if (q.size() == 0) begin
                check("spurious_write", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
                check("done_on_write", 32'(done), 32'(e.last));
            end
        end else if (!Reset) begin
            check("done_without_write", 32'(done), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        check_all_zero("reset");
        tick();
        Reset = 1'b0;
        tick();
        check("idle_ready", 32'(pix_ready), 32'd0);

        // Reset in the middle of a load
        begin_load();
        check("load_ready", 32'(pix_ready), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 137; i++) send(pal[i % 9], 1'b1, 1'b0);
        pix_valid = 1'b1;
        pix_rgb   = pal[137 % 9];
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check_all_zero("midreset");
        q.delete();
        pix_valid = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        check("post_reset_ready", 32'(pix_ready), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Full tile, back-to-back, cycling palette entries
        done_before = done_seen;
        begin_load();
        for (int i = 0; i < TP; i++) send(pal[i % 9], 1'b1, 1'b0);
        check("full_done", 32'(done), 32'd1);
        check("full_err", 32'(err), 32'd0);
        check("full_miss", 32'(miss_count), 32'd0);
        check("full_busy_done", 32'(busy), 32'd1);
        tick();
        check("full_done_count", 32'(done_seen - done_before), 32'd1);
        check("full_busy_after", 32'(busy), 32'd0);
        check("full_ready_after", 32'(pix_ready), 32'd0);

        // pix_valid toggling: gaps produce no writes
        done_before = done_seen;
        begin_load();
        for (int i = 0; i < 20; i++) send(pal[(i * 5) % 9], (i % 2) == 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("toggle_busy_after_abort", 32'(busy), 32'd0);
        check("toggle_no_done", 32'(done_seen - done_before), 32'd0);

        // Unmatched pixels at addresses 5 and 390
        begin_load();
        for (int i = 0; i < TP; i++)
            send((i == 5 || i == 390) ? 12'h123 : pal[(i * 7) % 9], 1'b1, 1'b0);
        check("miss_done", 32'(done), 32'd1);
        check("miss_err", 32'(err), 32'd1);
        check("miss_count", 32'(miss_count), 32'd2);
        tick();
        tick();
        check("miss_err_hold", 32'(err), 32'd1);
        check("miss_count_hold", 32'(miss_count), 32'd2);

        // Abort on the edge that accepts pixel 50
        done_before = done_seen;
        begin_load();
        check("restart_err_clear", 32'(err), 32'd0);
        check("restart_miss_clear", 32'(miss_count), 32'd0);
        for (int i = 0; i < 50; i++) send((i == 10) ? 12'hABC : pal[i % 9], 1'b1, 1'b0);
        send(pal[4], 1'b1, 1'b1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(pix_ready), 32'd0);
        check("abort_wr_en", 32'(wr_en), 32'd1);
        check("abort_wr_addr", 32'(wr_addr), 32'd50);
        check("abort_err", 32'(err), 32'd1);
        check("abort_miss", 32'(miss_count), 32'd1);
        tick();
        tick();
        check("abort_no_done", 32'(done_seen - done_before), 32'd0);
        begin_load();
        check("reabort_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) send(pal[8 - i], 1'b1, 1'b0);
        send(pal[0], 1'b1, 1'b1);
        tick();

        // start pulsed during LOAD and during DONE
        done_before = done_seen;
        begin_load();
        for (int i = 0; i < TP; i++) begin
            start = (i == 100) || (i == 250);
            send(pal[(i * 2) % 9], 1'b1, 1'b0);
        end
        start = 1'b1;
        check("start_done", 32'(done), 32'd1);
        tick();
        start = 1'b0;
        check("start_in_done_busy", 32'(busy), 32'd0);
        check("start_in_done_ready", 32'(pix_ready), 32'd0);
        tick();
        check("start_in_done_idle", 32'(pix_ready), 32'd0);
        check("start_done_count", 32'(done_seen - done_before), 32'd1);

        // Drain scoreboard
        for (int i = 0; i < 5 && q.size() != 0; i++) tick();
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_tile_writer.md
# sprite_tile_writer

Write-side companion to the on-chip sprite tile memories. Accepts a stream of 12-bit RGB pixels over a valid/ready handshake, encodes each pixel to its 4-bit palette index, and drives the write port of a 400-entry (20×20) tile memory in raster order. Sits between the sprite loader and the per-tile RAMs, so tile contents can be replaced at run time instead of only at initialisation.

## Interface
Parameters:
- TILE_PIXELS, 400, pixels per tile; the last write address is TILE_PIXELS-1.
- ADDR_W, 9, width of the write address; must satisfy 2^ADDR_W ≥ TILE_PIXELS.
- IDX_W, 4, palette index width.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  begins a tile load; sampled in IDLE only.
- abort  in  1  ends a load early; sampled in LOAD only.
- pix_valid  in  1  pixel on pix_rgb is valid.
- pix_rgb  in  12  pixel colour, 4:4:4 RGB.
- pix_ready  out  1  writer accepts a pixel this cycle.
- wr_en  out  1  tile memory write strobe.
- wr_addr  out  ADDR_W  tile memory write address.
- wr_data  out  IDX_W  palette index to write.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse after the last pixel is written.
- err  out  1  sticky flag: at least one pixel of the current load had no palette match.
- miss_count  out  ADDR_W  number of unmatched pixels in the current load; saturates at TILE_PIXELS.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on start.
  - LOAD → DONE on acceptance of pixel TILE_PIXELS-1.
  - LOAD → IDLE on abort, with no done pulse.
  - DONE → IDLE unconditionally after one cycle.
- Entering LOAD clears the internal pixel counter, err and miss_count.
- pix_ready = (state == LOAD). It is decoded from registered state only and never depends on pix_valid.
- A pixel is accepted on a rising edge where pix_valid && pix_ready.
- Encoding compares pix_rgb against the fixed 9-entry palette:
  - index 0 = 808, 1 = 887, 2 = 000, 3 = FEF, 4 = FC9, 5 = E50, 6 = A30, 7 = 765, 8 = E30.
  - On multiple matches, the lowest index wins.
  - On no match, wr_data = 0 (transparent), err is set and miss_count increments.
- Addresses are raster order, 0 to TILE_PIXELS-1. The counter never wraps; the FSM leaves LOAD first.
- start in LOAD or DONE is ignored. abort outside LOAD is ignored.
- If abort and an accepted pixel land on the same edge, the pixel is written and the FSM then goes to IDLE.
- Reset mid-load: all outputs return to reset values immediately. Tile memory contents are undefined and must be reloaded.

## Timing
- Reset values: pix_ready 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, err 0, miss_count 0. State is IDLE.
- All outputs except pix_ready are registered.
- Latency: pixel accepted at edge N gives wr_en/wr_addr/wr_data valid for the cycle after edge N, i.e. one write per cycle.
- wr_en is low in every cycle with no accepted pixel in the preceding edge.
- Throughput: one pixel per cycle with pix_valid held high. A full tile takes 400 cycles in LOAD plus 1 cycle in DONE.
- done is asserted in the same cycle as wr_en for address TILE_PIXELS-1.
- err and miss_count include that final pixel in the same cycle that done is high.
- err and miss_count hold their values through IDLE until the next start.

## Structure
- Shared package sprite_pkg holds:
  - the palette as a localparam array of 12-bit constants;
  - PAL_N = 9;
  - IDX_W and the tile dimension constants;
  - the FSM state enum.
- The palette constants in sprite_pkg are the same values the read-side tile RAMs use, so both ends stay consistent.
- One sub-module: sprite_palette_encoder, a purely combinational block that maps 12-bit RGB to an IDX_W index plus a hit flag. It is reusable by other sprite writers.

## Test plan
- Reset asserted mid-load at pixel 137 → all outputs 0 within the same cycle, and state is IDLE after release.
- Start, then 400 back-to-back pixels cycling through palette entries 0–8 → 400 writes at addresses 0..399 with data i mod 9, done pulses exactly once on the addr-399 write, err = 0.
- pix_valid toggling 1,0,1,0 during a load → wr_en follows one cycle later, addresses stay contiguous, and no writes occur in gap cycles.
- Pixels 0x123 at addresses 5 and 390, all others valid → wr_data = 0 at both addresses, err = 1, miss_count = 2 at done.
- abort on the edge that accepts pixel 50 → address 50 is written, done is never asserted, busy = 0 on the next cycle, and a new start restarts at address 0 with err cleared.
- start pulsed during LOAD and during DONE → no effect on the address sequence or the done count.
